cipher_round_scheduler: RTL and testbench

Sequences a shared single-stage cipher datapath over multiple rounds and arbitrates it among NUM_REQ requesters. The datapath registers its output one cycle after it samples core_data_in and core_key. This block runs one job at a time:
- grants a requester (round-robin),
- latches that requester's block and key,
- feeds the core once per round with a derived round key,
- returns the result with the requester's ID on a valid/ready response channel.

It sits between the crypto request clients and the cipher core.

---
 rtl/cipher_round_scheduler_if.sv | 29 ++
 rtl/cipher_round_scheduler.sv | 120 ++++++++++++
 tb/tb_cipher_round_scheduler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_round_scheduler_if.sv
// Request, response and cipher-core signals of the round scheduler in one bundle.
// The scheduler uses the slave side; requesters and the core sit on the master side.
interface cipher_round_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic [127:0]           core_data_in;
    logic [127:0]           core_key;
    logic [127:0]           core_data_out;
    logic                   busy;

    modport master (
        output req_valid, req_data, req_key, rsp_ready, core_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_id, core_data_in, core_key, busy
    );

    modport slave (
        input  req_valid, req_data, req_key, rsp_ready, core_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_id, core_data_in, core_key, busy
    );
endinterface

// File: rtl/cipher_round_scheduler.sv
// Round-robin arbiter and round sequencer for a shared single-stage cipher core.
// One job at a time: grant, latch block/key, ISSUE/WAIT per round, then respond.
//
// state | meaning
// IDLE  | scanning requesters from the RR pointer, req_ready live
// ISSUE | state and rk(round) presented to the core
// WAIT  | core output captured into the working state
// RESP  | result held on rsp_* until rsp_ready
module cipher_round_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ROUNDS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cipher_round_scheduler_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0]      LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [ID_W-1:0] LAST_REQ   = ID_W'(NUM_REQ - 1);

    logic [1:0]         r_fsm;
    logic [7:0]         r_round;
    logic [127:0]       r_state;
    logic [127:0]       r_key;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic               r_rsp_valid;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic [ID_W-1:0]    w_scan;
    logic               w_found;
    logic [ID_W-1:0]    w_next_ptr;

    // The shift amount wraps every 16 rounds; a shift of 128 on the right half yields zero.
    function automatic logic [127:0] f_round_key(input logic [127:0] key, input logic [7:0] rnd);
        logic [6:0] sh;
        logic [7:0] rsh;
        sh  = 7'({rnd, 3'b000});
        rsh = 8'd128 - {1'b0, sh};
        return ((key << sh) | (key >> rsh)) ^ {120'b0, rnd};
    endfunction

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_scan      = '0;
        w_found     = 1'b0;
        if (r_fsm == S_IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = ID_W'((int'(r_ptr) + k) % NUM_REQ);
                if (!w_found && bus.req_valid[w_scan]) begin
                    w_found     = 1'b1;
                    w_grant_idx = w_scan;
                end
            end
            if (w_found) begin
                w_grant = NUM_REQ'(1) << w_grant_idx;
            end
        end
    end

    assign w_next_ptr = (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_round     <= '0;
            r_state     <= '0;
            r_key       <= '0;
            r_ptr       <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= bus.req_data[128*w_grant_idx +: 128];
                        r_key   <= bus.req_key[128*w_grant_idx +: 128];
                        r_id    <= w_grant_idx;
                        r_round <= '0;
                        r_ptr   <= w_next_ptr;
                        r_fsm   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_fsm <= S_WAIT;
                S_WAIT: begin
                    r_state <= bus.core_data_out;
                    if (r_round == LAST_ROUND) begin
                        r_fsm       <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 8'd1;
                        r_fsm   <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.core_data_in = r_state;
    assign bus.core_key     = f_round_key(r_key, r_round);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_state;
    assign bus.rsp_id       = r_id;
    assign bus.busy         = (r_fsm != S_IDLE);
endmodule

// File: tb/tb_cipher_round_scheduler.sv
// Bench for cipher_round_scheduler: ROUNDS=1/2 instances with literal checks,
// ROUNDS=4 instance checked every cycle against a job-level model (XOR core).
module tb_cipher_round_scheduler;
    localparam int N  = 4;
    localparam int R4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    cipher_round_scheduler_if #(.NUM_REQ(N), .ID_W(2)) if1 ();
    cipher_round_scheduler_if #(.NUM_REQ(N), .ID_W(2)) if2 ();
    cipher_round_scheduler_if #(.NUM_REQ(N), .ID_W(2)) if4 ();

    cipher_round_scheduler #(.NUM_REQ(N), .ID_W(2), .ROUNDS(1))  u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    cipher_round_scheduler #(.NUM_REQ(N), .ID_W(2), .ROUNDS(2))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    cipher_round_scheduler #(.NUM_REQ(N), .ID_W(2), .ROUNDS(R4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    // Bench cipher cores: registered XOR of data and round key
    always @(posedge clk) begin
        if1.core_data_out <= rst ? 128'h0 : (if1.core_data_in ^ if1.core_key);
        if2.core_data_out <= rst ? 128'h0 : (if2.core_data_in ^ if2.core_key);
        if4.core_data_out <= rst ? 128'h0 : (if4.core_data_in ^ if4.core_key);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rk(input logic [127:0] k, input int r);
        logic [255:0] d;
        d = {k, k} << ((8 * r) % 128);
        return d[255:128] ^ 128'(r % 256);
    endfunction

    function automatic logic [127:0] run_rounds(input logic [127:0] data, input logic [127:0] key, input int n);
        logic [127:0] s;
        s = data;
        for (int i = 0; i < n; i++) s = s ^ rk(key, i);
        return s;
    endfunction

    // Job-level model of the ROUNDS=4 instance
    bit           m_on = 1'b0;
    bit           m_active = 1'b0;
    int           m_cyc = 0;
    int           m_ptr = 0;
    int           m_id = 0;
    logic [127:0] m_data = '0;
    logic [127:0] m_key = '0;

    always @(negedge clk) begin
        logic [3:0] exp_ready;
        int         exp_idx;
        bit         exp_rv;
        exp_ready = '0;
        exp_idx   = 0;
        exp_rv    = m_active && (m_cyc > 2 * R4);
        if (!m_active) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (if4.req_valid[(m_ptr + k) % N]) exp_idx = (m_ptr + k) % N;
            end
            if (if4.req_valid != 0) exp_ready[exp_idx] = 1'b1;
        end
        if (m_on) begin
            chk("req_ready", 128'(if4.req_ready), 128'(exp_ready));
            chk("busy", 128'(if4.busy), 128'(m_active));
            chk("rsp_valid", 128'(if4.rsp_valid), 128'(exp_rv));
            if (m_active && m_cyc <= 2 * R4) begin
                chk("core_key", if4.core_key, rk(m_key, (m_cyc - 1) / 2));
                chk("core_data_in", if4.core_data_in, run_rounds(m_data, m_key, (m_cyc - 1) / 2));
            end
            if (exp_rv) begin
                chk("rsp_data", if4.rsp_data, run_rounds(m_data, m_key, R4));
                chk("rsp_id", 128'(if4.rsp_id), 128'(m_id));
            end
        end
        if (rst) begin
            m_on     = 1'b1;
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (m_on) begin
            if (!m_active) begin
                if (exp_ready != 0) begin
                    m_active = 1'b1;
                    m_cyc    = 1;
                    m_id     = exp_idx;
                    m_data   = if4.req_data[128*exp_idx +: 128];
                    m_key    = if4.req_key[128*exp_idx +: 128];
                    m_ptr    = (exp_idx + 1) % N;
                end
            end else if (exp_rv) begin
                if (if4.rsp_ready) m_active = 1'b0;
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic wait_grant4(input string name, output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if4.req_ready != 0) begin
                g = if4.req_ready;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: no grant within 100 cycles", name);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] grants [5];
        logic [3:0] exp_order [5];
        bit seen;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        if1.req_valid = '0; if1.req_data = '0; if1.req_key = '0; if1.rsp_ready = 1'b0;
        if2.req_valid = '0; if2.req_data = '0; if2.req_key = '0; if2.rsp_ready = 1'b0;
        if4.req_valid = '0; if4.req_data = '0; if4.req_key = '0; if4.rsp_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", 128'(if4.busy), 128'(0));
        chk("rst_rsp_valid", 128'(if4.rsp_valid), 128'(0));
        chk("rst_rsp_data", if4.rsp_data, 128'h0);
        chk("rst_rsp_id", 128'(if4.rsp_id), 128'(0));
        chk("rst_core_key", if4.core_key, 128'h0);
        chk("rst_core_data_in", if4.core_data_in, 128'h0);
        step();
        rst = 1'b0;

        // ROUNDS=1, requester 2, XOR core
        if1.req_data[2*128 +: 128] = 128'hFFFF0000;
        if1.req_key[2*128 +: 128]  = 128'h0000FFFF;
        if1.req_valid = 4'b0100;
        @(negedge clk);
        chk("r1_grant", 128'(if1.req_ready), 128'(4'b0100));
        step();
        if1.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("r1_valid_early", 128'(if1.rsp_valid), 128'(0));
        @(negedge clk);
        chk("r1_valid", 128'(if1.rsp_valid), 128'(1));
        chk("r1_data", if1.rsp_data, 128'hFFFFFFFF);
        chk("r1_id", 128'(if1.rsp_id), 128'(2));
        step();
        if1.rsp_ready = 1'b1;

        // ROUNDS=2, data 0, key 1: rk0=1, rk1=0x101
        if2.req_data[0 +: 128] = 128'h0;
        if2.req_key[0 +: 128]  = 128'h1;
        if2.req_valid = 4'b0001;
        @(negedge clk);
        chk("r2_grant", 128'(if2.req_ready), 128'(4'b0001));
        step();
        if2.req_valid = '0;
        @(negedge clk);
        chk("r2_rk0", if2.core_key, 128'h1);
        @(negedge clk);
        @(negedge clk);
        chk("r2_rk1", if2.core_key, 128'h101);
        @(negedge clk);
        chk("r2_valid_early", 128'(if2.rsp_valid), 128'(0));
        @(negedge clk);
        chk("r2_valid", 128'(if2.rsp_valid), 128'(1));
        chk("r2_data", if2.rsp_data, 128'h100);
        step();
        if2.rsp_ready = 1'b1;

        // ROUNDS=4: four requesters continuously valid
        for (int i = 0; i < N; i++) begin
            if4.req_data[128*i +: 128] = {32'hC0DE_0000 + 32'(i), 96'h0123_4567_89AB_CDEF_1357_9BDF};
            if4.req_key[128*i +: 128]  = {96'h0, 32'hF00D_0000 + 32'(i)} ^ (128'h1 << (i * 17 + 40));
        end
        if4.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant4("rr_grant_wait", g);
            grants[n] = g;
        end
        for (int n = 0; n < 5; n++) chk("rr_order", 128'(grants[n]), 128'(exp_order[n]));
        step();
        if4.rsp_ready = 1'b0;

        // Back-pressure: hold rsp_ready low for 5 cycles of rsp_valid
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = if4.rsp_valid;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL bp_wait: rsp_valid not seen within 40 cycles");
        end
        for (int i = 0; i < 4; i++) @(negedge clk);
        step();
        if4.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_grant", 128'(if4.req_ready), 128'(0));
        step();
        @(negedge clk);
        chk("bp_grant_after_hs", 128'(if4.req_ready), 128'(4'b0010));

        // Reset during WAIT of round 1
        step();
        step();
        step();
        step();
        rst = 1'b1;
        if4.req_valid = 4'b0001;
        @(negedge clk);
        chk("midjob_busy", 128'(if4.busy), 128'(1));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 128'(if4.busy), 128'(0));
        chk("post_rst_rsp_valid", 128'(if4.rsp_valid), 128'(0));
        chk("post_rst_grant", 128'(if4.req_ready), 128'(4'b0001));

        // Wrap-around: pointer=1, only requester 3 valid
        step();
        if4.req_valid = 4'b1000;
        if4.req_data[3*128 +: 128] = 128'h0BAD_F00D_0000_0000_DEAD_BEEF_1234_5678;
        wait_grant4("wrap_wait", g);
        chk("wrap_grant3", 128'(g), 128'(4'b1000));
        step();
        if4.req_valid = 4'b1001;
        wait_grant4("wrap_wait0", g);
        chk("wrap_grant0", 128'(g), 128'(4'b0001));
        step();
        if4.req_valid = 4'b1000;
        wait_grant4("final_wait3", g);
        chk("final_grant3", 128'(g), 128'(4'b1000));
        step();
        if4.req_valid = '0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("final_idle", 128'(if4.busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
